mblock_sequencer: RTL and testbench



---
 rtl/mblock_pkg.sv | 36 +++
 rtl/mblock_op_decode.sv | 41 ++++
 rtl/mblock_sequencer.sv | 131 +++++++++++++
 tb/tb_mblock_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mblock_pkg.sv
// Shared encodings for the memory-block sequencer: selector codes, op classes,
// FSM states and op-byte field positions.
package mblock_pkg;

  localparam int OP_S1_LSB    = 0;
  localparam int OP_S2_LSB    = 2;
  localparam int OP_S3_LSB    = 4;
  localparam int OP_CLASS_LSB = 6;

  typedef enum logic [1:0] {
    SEL_RAM   = 2'b00,
    SEL_BROM  = 2'b01,
    SEL_IO    = 2'b10,
    SEL_CONST = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    CLASS_THREE_OP = 2'b00,
    CLASS_TWO_OP   = 2'b01,
    CLASS_JUMP     = 2'b10,
    CLASS_HALT     = 2'b11
  } class_t;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic class_t op_class(input logic [7:0] op);
    return class_t'(op[OP_CLASS_LSB +: 2]);
  endfunction

endpackage

// File: rtl/mblock_op_decode.sv
// Combinational op-byte decode: per-stage selectors, write mask, last stage,
// and jump/halt flags.
module mblock_op_decode
  import mblock_pkg::*;
(
  input  logic [7:0] op,
  output sel_t       sel_s1,
  output sel_t       sel_s2,
  output sel_t       sel_s3,
  output logic [3:0] write_mask,
  output logic [1:0] last_stage,
  output logic       is_jump,
  output logic       is_halt
);

  always_comb begin
    sel_s1     = sel_t'(op[OP_S1_LSB +: 2]);
    sel_s2     = sel_t'(op[OP_S2_LSB +: 2]);
    sel_s3     = sel_t'(op[OP_S3_LSB +: 2]);
    write_mask = 4'b0000;
    last_stage = 2'd0;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    case (op_class(op))
      CLASS_THREE_OP: begin
        write_mask = 4'b1000;
        last_stage = 2'd3;
      end
      CLASS_TWO_OP: begin
        write_mask = 4'b0100;
        last_stage = 2'd2;
      end
      CLASS_JUMP: begin
        last_stage = 2'd1;
        is_jump    = 1'b1;
      end
      default: is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/mblock_sequencer.sv
// Per-instruction memory-block access sequencer: fetch, up to three operand
// stages, PC ownership, jump and halt.
module mblock_sequencer
  import mblock_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute_from_brom,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] jump_target,
  output logic        mem_req,
  output logic [1:0]  is_stage,
  output logic [1:0]  mblock_selector,
  output logic [3:0]  is_write,
  output logic [15:0] pc,
  output logic [7:0]  op_q,
  output logic        instr_done,
  output logic        halted,
  output logic        bad_op,
  output logic [2:0]  fsm_state
);

  // Handshake: an access is live while mem_req=1; it completes in the cycle
  // where mem_req & mem_ready, and all access outputs hold until then.

  localparam logic [15:0] INSTR_STEP = 16'(INSTR_BYTES);

  state_t     state, state_next;
  logic [7:0] decode_op;
  sel_t       sel_s1, sel_s2, sel_s3;
  logic [3:0] write_mask;
  logic [1:0] last_stage;
  logic       is_jump, is_halt;
  logic [1:0] stage_idx;
  sel_t       stage_sel;
  logic       stage_end;
  logic       const_write;

  // During FETCH the op is not latched yet, so decode the incoming byte.
  assign decode_op = (state == ST_FETCH) ? mem_rdata : op_q;
  assign fsm_state = state;

  mblock_op_decode u_decode (
    .op         (decode_op),
    .sel_s1     (sel_s1),
    .sel_s2     (sel_s2),
    .sel_s3     (sel_s3),
    .write_mask (write_mask),
    .last_stage (last_stage),
    .is_jump    (is_jump),
    .is_halt    (is_halt)
  );

  always_comb begin
    state_next      = state;
    mem_req         = 1'b0;
    is_stage        = 2'd0;
    mblock_selector = SEL_RAM;
    is_write        = 4'b0000;
    instr_done      = 1'b0;
    halted          = 1'b0;
    stage_idx       = 2'd0;
    stage_sel       = SEL_CONST;
    stage_end       = 1'b0;
    const_write     = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req         = 1'b1;
        mblock_selector = execute_from_brom ? SEL_BROM : SEL_RAM;
        if (mem_ready) state_next = is_halt ? ST_HALT : ST_S1;
      end
      ST_S1, ST_S2, ST_S3: begin
        case (state)
          ST_S1:   begin stage_idx = 2'd1; stage_sel = sel_s1; end
          ST_S2:   begin stage_idx = 2'd2; stage_sel = sel_s2; end
          default: begin stage_idx = 2'd3; stage_sel = sel_s3; end
        endcase
        is_stage        = stage_idx;
        mblock_selector = stage_sel;
        mem_req         = (stage_sel != SEL_CONST);
        // A write to the const selector is suppressed and flagged instead.
        if (write_mask[stage_idx]) begin
          if (stage_sel == SEL_CONST) const_write = 1'b1;
          else                        is_write    = 4'b0001 << stage_idx;
        end
        stage_end = (stage_sel == SEL_CONST) || mem_ready;
        if (stage_end) begin
          if (stage_idx == last_stage) begin
            instr_done = 1'b1;
            state_next = ST_FETCH;
          end else begin
            case (state)
              ST_S1:   state_next = ST_S2;
              default: state_next = ST_S3;
            endcase
          end
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_next = ST_FETCH;
    endcase
    if (reset) begin
      mem_req         = 1'b0;
      is_stage        = 2'd0;
      mblock_selector = SEL_RAM;
      is_write        = 4'b0000;
      instr_done      = 1'b0;
      halted          = 1'b0;
      const_write     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      op_q   <= 8'h00;
      bad_op <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem_ready) op_q <= mem_rdata;
      if (const_write) bad_op <= 1'b1;
      if (instr_done) pc <= is_jump ? jump_target : pc + INSTR_STEP;
    end
  end

endmodule

// File: tb/tb_mblock_sequencer.sv
// Bench for mblock_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against an instruction-level stage-list model.
module tb_mblock_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        execute_from_brom = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        mem_req;
  logic [1:0]  is_stage;
  logic [1:0]  mblock_selector;
  logic [3:0]  is_write;
  logic [15:0] pc;
  logic [7:0]  op_q;
  logic        instr_done;
  logic        halted;
  logic        bad_op;
  logic [2:0]  fsm_state;

  mblock_sequencer #(.RESET_PC(RESET_PC), .INSTR_BYTES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .execute_from_brom (execute_from_brom),
    .mem_rdata         (mem_rdata),
    .mem_ready         (mem_ready),
    .jump_target       (jump_target),
    .mem_req           (mem_req),
    .is_stage          (is_stage),
    .mblock_selector   (mblock_selector),
    .is_write          (is_write),
    .pc                (pc),
    .op_q              (op_q),
    .instr_done        (instr_done),
    .halted            (halted),
    .bad_op            (bad_op),
    .fsm_state         (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic [1:0] sel;
    logic       wr;
    logic [1:0] k;
  } stage_t;

  stage_t      m_stages[$];
  logic        m_valid = 1'b0;
  logic [15:0] m_pc;
  logic [7:0]  m_op;
  logic        m_bad;
  logic        m_halt;
  logic        m_jump;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand an op byte into its list of operand stages.
  task automatic model_load(input logic [7:0] op);
    int cls, n;
    stage_t s;
    cls = int'(op[7:6]);
    m_op = op;
    if (cls == 3) begin
      m_halt = 1'b1;
    end else begin
      n = (cls == 0) ? 3 : (cls == 1) ? 2 : 1;
      m_jump = (cls == 2);
      for (int k = 1; k <= n; k++) begin
        s.k   = 2'(k);
        s.sel = 2'((op >> (2 * (k - 1))) & 8'h3);
        s.wr  = (cls != 2) && (k == n);
        m_stages.push_back(s);
      end
    end
  endtask

  // driver: apply one cycle of inputs, check outputs mid-cycle, advance model
  task automatic step(input logic rst, input logic rdy, input logic [7:0] rd,
                      input logic brom, input logic [15:0] jt);
    logic       e_req, e_done, e_halt, chk_sel;
    logic [1:0] e_stage, e_sel;
    logic [3:0] e_wr;
    stage_t     s;
    reset = rst;
    mem_ready = rdy;
    mem_rdata = rd;
    execute_from_brom = brom;
    jump_target = jt;
    @(negedge clk);
    if (exp_q.size() > 0) check("pc_after_done", 32'(pc), 32'(exp_q.pop_front()));
    if (m_valid) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("op_q", 32'(op_q), 32'(m_op));
      check("bad_op", 32'(bad_op), 32'(m_bad));
    end
    e_req = 0; e_done = 0; e_halt = 0; e_stage = 0; e_sel = 0; e_wr = 0; chk_sel = 1;
    if (rst) begin
      m_valid = 1'b1;
      m_pc = RESET_PC; m_op = 8'h00; m_bad = 0; m_halt = 0; m_jump = 0;
      m_stages.delete();
    end else if (m_halt) begin
      e_halt = 1; chk_sel = 0;
    end else if (m_stages.size() == 0) begin
      e_req = 1;
      e_sel = {1'b0, brom};
      if (rdy) model_load(rd);
    end else begin
      s = m_stages[0];
      e_stage = s.k;
      e_sel = s.sel;
      e_req = (s.sel != 2'b11);
      e_wr = (s.wr && s.sel != 2'b11) ? (4'b0001 << s.k) : 4'b0000;
      if (s.sel == 2'b11 || rdy) begin
        void'(m_stages.pop_front());
        if (s.wr && s.sel == 2'b11) m_bad = 1'b1;
        if (m_stages.size() == 0) begin
          e_done = 1;
          m_pc = m_jump ? jt : m_pc + 16'd4;
          exp_q.push_back(m_pc);
        end
      end
    end
    check("mem_req", 32'(mem_req), 32'(e_req));
    check("is_stage", 32'(is_stage), 32'(e_stage));
    check("is_write", 32'(is_write), 32'(e_wr));
    check("instr_done", 32'(instr_done), 32'(e_done));
    check("halted", 32'(halted), 32'(e_halt));
    if (chk_sel) check("mblock_selector", 32'(mblock_selector), 32'(e_sel));
    if (rst) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ready(input logic [7:0] op, input int n, input logic [15:0] jt);
    step(1'b0, 1'b1, op, 1'b1, jt);
    for (int i = 1; i < n; i++) step(1'b0, 1'b1, 8'h00, 1'b1, jt);
  endtask

  initial begin
    logic [7:0] rd;
    // reset, then op 00 with zero wait from BROM: 4 cycles each
    step(1'b1, 1'b1, 8'h00, 1'b1, 16'h0);
    step(1'b1, 1'b1, 8'h00, 1'b1, 16'h0);
    check("reset_pc", 32'(pc), 32'(RESET_PC));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, 1'b1, 16'h0);
    check("pc_three_instr", 32'(pc), 32'h000C);

    // op 46: S1 on I/O held 3 wait cycles, S2 writes BROM
    step(1'b0, 1'b1, 8'h46, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 16'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 16'h0);
    check("pc_two_op", 32'(pc), 32'h0010);

    // jump
    run_ready(8'h80, 2, 16'h1234);
    check("pc_jump", 32'(pc), 32'h1234);

    // const write stage
    run_ready(8'h3F, 4, 16'h0);
    check("bad_op_latched", 32'(bad_op), 32'h1);

    // wrap FFFC -> 0000
    run_ready(8'h80, 2, 16'hFFFC);
    run_ready(8'h40, 3, 16'h0);
    check("pc_wrap", 32'(pc), 32'h0000);

    // reset mid-S2 at pc FFFC
    run_ready(8'h80, 2, 16'hFFFC);
    run_ready(8'h00, 2, 16'h0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 16'h0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 16'h0);
    check("pc_after_reset", 32'(pc), 32'(RESET_PC));
    step(1'b0, 1'b1, 8'h00, 1'b1, 16'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom_range(0, 255));
      if (rd[7:6] == 2'b11 && $urandom_range(0, 3) != 0) rd[7:6] = 2'b00;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rd,
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    // halt holds regardless of mem_ready; only reset exits
    step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
    step(1'b0, 1'b1, 8'hC0, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 16'h0);
    check("halted_hold", 32'(halted), 32'h1);
    step(1'b1, 1'b1, 8'h00, 1'b0, 16'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 16'h0);
    check("fetch_after_halt", 32'(pc), 32'(RESET_PC));

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
